// File: rtl/rotation_reader.sv
// rotation_reader: streams one rotated copy of a square 8-bit image held in BRAM.
// Each output pixel (raster order) is inverse-mapped through a rotation about the
// image centre. The source address is issued to BRAM and the returned pixel is emitted.
// The rotation angle is picked once per image from a small LFSR-indexed table.
module rotation_reader #(
    parameter int          IMG_W     = 28,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        interrupt,
    output logic        image_done,
    output logic [7:0]  pixel_o,
    output logic        pixel_valid,
    output logic [31:0] bram_address,
    input  logic [31:0] bram_data
);

    localparam int                 CW       = $clog2(IMG_W);
    localparam logic [CW-1:0]      LAST     = CW'(IMG_W - 1);
    localparam logic signed [31:0] CENTRE   = 32'(IMG_W / 2);
    localparam logic signed [31:0] IMG_W_S  = 32'(IMG_W);
    localparam logic signed [31:0] ROUND_HF = 32'sd8192;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [CW-1:0]      xo, yo;
    logic [15:0]        lfsr, lfsr_next;
    logic signed [31:0] sin_q, cos_q, sin_sel, cos_sel;
    logic signed [31:0] dx, dy, x_acc, y_acc, xs, ys, lin;
    logic [31:0]        addr_calc;
    logic               in_range;
    logic               last_pixel, pipe_empty;

    logic               v1, flag1;
    logic               v2, flag2;
    logic               pv_q;
    logic [7:0]         pix_q;
    logic               stalled;
    logic [7:0]         data_hold;
    logic [7:0]         s2_pixel;

    logic               unused_bits;

    assign unused_bits = ^{bram_data[31:8], lin[31:30]};

    // Next LFSR value: Fibonacci form of x^16+x^14+x^13+x^11+1, shifting right
    always_comb begin
        lfsr_next = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    // Angle table indexed by the freshly stepped LFSR; sin/cos in signed Q1.14
    always_comb begin
        sin_sel = 32'sd0;
        cos_sel = 32'sd16384;
        unique case (lfsr_next[2:0])
            3'd1: begin sin_sel =  32'sd1428; cos_sel = 32'sd16322; end
            3'd2: begin sin_sel =  32'sd2845; cos_sel = 32'sd16135; end
            3'd3: begin sin_sel =  32'sd4240; cos_sel = 32'sd15826; end
            3'd4: begin sin_sel = -32'sd4240; cos_sel = 32'sd15826; end
            3'd5: begin sin_sel = -32'sd2845; cos_sel = 32'sd16135; end
            3'd6: begin sin_sel = -32'sd1428; cos_sel = 32'sd16322; end
            default: begin sin_sel = 32'sd0; cos_sel = 32'sd16384; end
        endcase
    end

    // Inverse rotation of the current output coordinate into source space
    always_comb begin
        dx        = $signed(32'(xo)) - CENTRE;
        dy        = $signed(32'(yo)) - CENTRE;
        x_acc     = cos_q * dx + sin_q * dy + ROUND_HF;
        y_acc     = cos_q * dy - sin_q * dx + ROUND_HF;
        xs        = (x_acc >>> 14) + CENTRE;
        ys        = (y_acc >>> 14) + CENTRE;
        in_range  = (xs >= 32'sd0) && (xs < IMG_W_S) && (ys >= 32'sd0) && (ys < IMG_W_S);
        lin       = ys * IMG_W_S + xs;
        addr_calc = BASE_ADDR + {lin[29:0], 2'b00};
    end

    // Pipeline occupancy and end-of-image detection feeding the FSM
    always_comb begin
        last_pixel = (xo == LAST) && (yo == LAST);
        pipe_empty = !v1 && !v2;
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and gated outputs; nothing advances while interrupt is high
    always_comb begin
        state_next  = state;
        image_done  = 1'b0;
        pixel_valid = pv_q && !interrupt;
        pixel_o     = pix_q;
        unique case (state)
            IDLE:  if (start) state_next = RUN;
            RUN:   if (!interrupt && last_pixel) state_next = DRAIN;
            DRAIN: if (!interrupt && pipe_empty) state_next = DONE;
            DONE: begin
                image_done = !interrupt;
                if (!interrupt) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Pixel for the S3 load: after a stall the BRAM output has moved on, so use the held copy
    always_comb begin
        s2_pixel = stalled ? data_hold : bram_data[7:0];
    end

    // Datapath: angle latch, output counters and the three pipeline stages
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr         <= LFSR_SEED;
            sin_q        <= 32'sd0;
            cos_q        <= 32'sd0;
            xo           <= '0;
            yo           <= '0;
            bram_address <= BASE_ADDR;
            v1           <= 1'b0;
            flag1        <= 1'b0;
            v2           <= 1'b0;
            flag2        <= 1'b0;
            pv_q         <= 1'b0;
            pix_q        <= 8'd0;
            stalled      <= 1'b0;
            data_hold    <= 8'd0;
        end else begin
            if (state == IDLE && start) begin
                lfsr  <= lfsr_next;
                sin_q <= sin_sel;
                cos_q <= cos_sel;
                xo    <= '0;
                yo    <= '0;
            end
            if (!interrupt) begin
                if (state == RUN) begin
                    bram_address <= in_range ? addr_calc : BASE_ADDR;
                    flag1        <= !in_range;
                    v1           <= 1'b1;
                    if (xo == LAST) begin
                        xo <= '0;
                        yo <= (yo == LAST) ? '0 : yo + 1'b1;
                    end else begin
                        xo <= xo + 1'b1;
                    end
                end else begin
                    bram_address <= BASE_ADDR;
                    flag1        <= 1'b0;
                    v1           <= 1'b0;
                end
                v2      <= v1;
                flag2   <= flag1;
                pv_q    <= v2;
                pix_q   <= (v2 && !flag2) ? s2_pixel : 8'd0;
                stalled <= 1'b0;
            end else begin
                stalled <= 1'b1;
                if (!stalled) begin
                    data_hold <= bram_data[7:0];
                end
            end
        end
    end

endmodule

// File: tb/tb_rotation_reader.sv
// Testbench for rotation_reader: BRAM model holding pixel[i] = i mod 256, a
// floating-point reference of the rotation, randomized stalls and restart pulses.
module tb_rotation_reader;

    localparam int NPIX = 28 * 28;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        interrupt = 1'b0;
    logic        image_done;
    logic [7:0]  pixel_o;
    logic        pixel_valid;
    logic [31:0] bram_address;
    logic [31:0] bram_data = 32'd0;

    int checks = 0;
    int errors = 0;
    int cycle = 0;

    logic [7:0] got[$];
    int         vcyc[$];
    int         doneTotal = 0;
    int         lastDoneCycle = 0;
    int         stallValid = 0;
    int         doneInStall = 0;

    logic [15:0] lfsrModel = 16'hACE1;
    int          expQ[$];
    bit          sawPlus15 = 1'b0;

    rotation_reader #(.IMG_W(28), .BASE_ADDR(32'h0), .LFSR_SEED(16'hACE1)) dut (
        .clk(clk), .reset(reset), .start(start), .interrupt(interrupt),
        .image_done(image_done), .pixel_o(pixel_o), .pixel_valid(pixel_valid),
        .bram_address(bram_address), .bram_data(bram_data)
    );

    always #5 clk = ~clk;

    // Cycle counter advancing on each rising edge
    always @(posedge clk) cycle <= cycle + 1;

    // BRAM model with one cycle read latency
    always @(posedge clk) bram_data <= 32'((bram_address / 4) % 256);

    // Output monitor sampling on the falling edge
    always @(negedge clk) begin
        if (pixel_valid) begin
            got.push_back(pixel_o);
            vcyc.push_back(cycle);
            if (interrupt) stallValid <= stallValid + 1;
        end
        if (image_done) begin
            doneTotal <= doneTotal + 1;
            lastDoneCycle <= cycle;
            if (interrupt) doneInStall <= doneInStall + 1;
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
        end
    endtask

    function automatic logic [15:0] stepLfsr(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic int q14(input real deg);
        real r;
        r = $sin(deg * 3.14159265358979 / 180.0) * 16384.0;
        if (r >= 0.0) return $rtoi(r + 0.5);
        return -$rtoi(-r + 0.5);
    endfunction

    // Reference stream: real-valued trig, nearest-integer rounding of the mapped coordinate
    task automatic buildExpected(input int idx);
        int  degTab[8];
        int  s, c, ax, ay, xs, ys;
        degTab = '{0, 5, 10, 15, -15, -10, -5, 0};
        s = q14(real'(degTab[idx]));
        c = q14(90.0 - real'(degTab[idx]));
        expQ.delete();
        for (int y = 0; y < 28; y++) begin
            for (int x = 0; x < 28; x++) begin
                ax = c * (x - 14) + s * (y - 14) + 8192;
                ay = c * (y - 14) - s * (x - 14) + 8192;
                xs = $rtoi($floor(real'(ax) / 16384.0)) + 14;
                ys = $rtoi($floor(real'(ay) / 16384.0)) + 14;
                if (xs >= 0 && xs < 28 && ys >= 0 && ys < 28) expQ.push_back((ys * 28 + xs) % 256);
                else expQ.push_back(0);
            end
        end
    endtask

    function automatic int gotAt(input int i);
        if (i < got.size()) return int'(got[i]);
        return -1;
    endfunction

    // Runs one image, optionally stalling and re-pulsing start, then checks the stream
    task automatic applyStimulus(input int stallAt, input int stallLen, input int restartAt,
                                 output int imgBase, output int angleIdx);
        int  dBase, sBase, iBase, startCycle, emitted, bad, n;
        bit  stallDone, rsDone;
        lfsrModel = stepLfsr(lfsrModel);
        angleIdx  = int'(lfsrModel[2:0]);
        buildExpected(angleIdx);
        imgBase = got.size();
        dBase = doneTotal; sBase = stallValid; iBase = doneInStall;
        stallDone = 1'b0; rsDone = 1'b0;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 startCycle = cycle; start = 1'b0;
        for (n = 0; n < 3000 && doneTotal == dBase; n++) begin
            @(posedge clk); #1;
            emitted = got.size() - imgBase;
            if (stallLen > 0 && !stallDone && emitted >= stallAt) begin
                interrupt = 1'b1;
                repeat (stallLen) @(posedge clk);
                #1 interrupt = 1'b0;
                stallDone = 1'b1;
            end
            if (restartAt >= 0 && !rsDone && emitted >= restartAt) begin
                start = 1'b1;
                @(posedge clk); #1 start = 1'b0;
                rsDone = 1'b1;
            end
        end
        checkOutput("image_done within bound", 32'(n < 3000), 32'd1);
        repeat (5) @(posedge clk);
        #1;
        checkOutput("image_done count", 32'(doneTotal - dBase), 32'd1);
        checkOutput("pixel count", 32'(got.size() - imgBase), 32'(NPIX));
        bad = 0;
        for (int i = 0; i < NPIX; i++) if (gotAt(imgBase + i) != expQ[i]) bad++;
        checkOutput("pixel mismatches", 32'(bad), 32'd0);
        checkOutput("valid during stall", 32'(stallValid - sBase), 32'd0);
        checkOutput("done during stall", 32'(doneInStall - iBase), 32'd0);
        if (stallLen == 0 && restartAt < 0 && got.size() > imgBase) begin
            checkOutput("first valid latency", 32'(vcyc[imgBase] - startCycle), 32'd3);
            checkOutput("done after last valid", 32'(lastDoneCycle - vcyc[vcyc.size() - 1]), 32'd1);
        end
        if (angleIdx == 3) begin
            sawPlus15 = 1'b1;
            checkOutput("+15 corner pixel", 32'(gotAt(imgBase)), 32'd0);
            checkOutput("+15 centre pixel", 32'(gotAt(imgBase + 14 * 28 + 14)), 32'd150);
        end
    endtask

    initial begin
        int base, idx, dBase, sl;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset pixel_valid", 32'(pixel_valid), 32'd0);
        checkOutput("reset pixel_o", 32'(pixel_o), 32'd0);
        checkOutput("reset image_done", 32'(image_done), 32'd0);
        checkOutput("reset bram_address", bram_address, 32'd0);

        applyStimulus(0, 0, -1, base, idx);
        checkOutput("identity pixel 100", 32'(gotAt(base + 100)), 32'd100);
        checkOutput("identity pixel 783", 32'(gotAt(base + 783)), 32'd15);
        applyStimulus(300, 6, -1, base, idx);
        applyStimulus(0, 0, 100, base, idx);

        lfsrModel = stepLfsr(lfsrModel);
        dBase = doneTotal;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (200) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        lfsrModel = 16'hACE1;
        checkOutput("mid reset pixel_valid", 32'(pixel_valid), 32'd0);
        checkOutput("mid reset pixel_o", 32'(pixel_o), 32'd0);
        checkOutput("mid reset bram_address", bram_address, 32'd0);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("no done after abort", 32'(doneTotal - dBase), 32'd0);

        for (int k = 0; k < 6; k++) begin
            sl = ($urandom % 2 == 0) ? int'($urandom_range(1, 8)) : 0;
            applyStimulus(int'($urandom_range(50, 700)), sl, -1, base, idx);
        end
        checkOutput("saw +15 image", 32'(sawPlus15), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
